if_id_unit: RTL and testbench
=============================

Name: if_id_unit

Overview:
- Fetch/decode stage that sits directly upstream of the multi-cycle control unit of the CPU core.
- Owns the PC and the instruction register (IR).
- Fetches from instruction memory over a req/ack handshake when the control unit pulses IR_Write, and advances the PC on PC_Write.
- Decodes the IR into opcode/funct3/funct7/register fields and a 32-bit immediate, which feed the control unit and the register file/ALU datapath.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset; must be word aligned.
- TIMEOUT, 15, max FETCH cycles without imem_ack before the fetch is abandoned (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- PC_Write  in  1  PC advance request from control unit.
- IR_Write  in  1  instruction fetch request from control unit.
- imem_req  out  1  memory request, held until ack or timeout.
- imem_addr  out  32  fetch address (= pc).
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_ack  in  1  memory completion strobe.
- fetch_busy  out  1  high while in FETCH; control unit must stall.
- fetch_err  out  1  sticky timeout flag.
- pc  out  32  current PC.
- opcode  out  7  IR[6:0].
- funct3  out  3  IR[14:12].
- funct7  out  7  IR[31:25].
- rs1  out  5  IR[19:15].
- rs2  out  5  IR[24:20].
- rd  out  5  IR[11:7].
- imm  out  32  decoded immediate.
- illegal  out  1  opcode not supported.

Behaviour:
- Synchronous reset (rst_n=0 at a rising edge) sets:
  - state=IDLE, pc=PC_RESET, IR=32'h0000_0013 (addi x0,x0,0).
  - imem_req=0, fetch_busy=0, fetch_err=0, pending_inc=0, wait counter=0.
  - Reset overrides everything, including mid-FETCH; an imem_ack in the reset cycle is ignored.
- FSM states are IDLE and FETCH. All control outputs are registered.
- IDLE:
  - IR_Write=1 → FETCH. Set imem_req=1 and fetch_busy=1, clear the counter, and set pending_inc=PC_Write.
  - PC_Write=1 with IR_Write=0 → pc <= pc+4 next edge.
  - imem_ack in IDLE is ignored.
- FETCH:
  - imem_addr=pc, held stable for the whole request.
  - imem_ack=1 → IR <= imem_rdata, imem_req=0, fetch_busy=0, state → IDLE. If pending_inc is set, pc <= pc+4 on the same edge, then pending_inc clears.
  - No ack and counter==TIMEOUT → fetch_err <= 1, state → IDLE, req and busy drop, IR unchanged, pc unchanged, pending_inc cleared.
  - Otherwise the counter increments.
  - Ack in the same cycle as the timeout: ack wins and no error is raised.
  - IR_Write or PC_Write asserted during FETCH is ignored; this is a control-unit protocol violation.
- Latency:
  - IR_Write sampled at edge E0 → imem_req high after E0.
  - Zero-wait ack sampled at E1 → new IR and decoded fields valid after E1.
  - Minimum 2 cycles from request to decoded instruction. Each wait state adds 1 cycle.
- PC arithmetic: modulo 2^32 (32'hFFFF_FFFC+4 = 0). pc[1:0] is always 0.
- fetch_err is cleared only by reset. Later fetches still operate normally while it is set.
- Decode is combinational from IR only; it never looks at imem_rdata directly.
- Immediate and illegal decode by opcode:
  - 0010011, 0000011, 1100111 (I-type): imm = sign-extended IR[31:20].
  - 0110111, 0010111 (U-type): imm = {IR[31:12], 12'b0}.
  - 0110011 (R-type): imm = 0.
  - Any other opcode: imm = 0, illegal=1; otherwise illegal=0.

Test Plan:
- Reset → pc=0, opcode=7'b0010011, imm=0, imem_req=0, fetch_busy=0, fetch_err=0, illegal=0.
- Zero-wait fetch: IR_Write=PC_Write=1 for 1 cycle; ack next cycle with rdata=32'hFFF0_8093 → after ack edge: opcode=0010011, rd=1, rs1=1, funct3=0, imm=32'hFFFF_FFFF, pc=4.
- Wait states: ack 3 cycles after req with rdata=32'h1234_50B7 → imem_addr constant for all 4 FETCH cycles, fetch_busy high 4 cycles, imm=32'h1234_5000, rd=1.
- R-type: rdata=32'h4020_81B3 → opcode=0110011, funct7=0100000, rs2=2, rs1=1, rd=3, imm=0, illegal=0; rdata=32'h0000_007F → illegal=1.
- Timeout: req with no ack → after TIMEOUT+1 FETCH cycles fetch_err=1, imem_req=0, IR and pc unchanged. Ack on exactly the last cycle → no error, IR loaded.
- Reset mid-FETCH with ack in the same cycle → IR=NOP, pc=PC_RESET, req=0. Also PC_RESET=32'hFFFF_FFFC with PC_Write → pc=0.

Source files
------------

// File: rtl/if_id_unit.sv
// Fetch/decode stage: owns PC and IR, fetches over a req/ack handshake with timeout,
// and decodes the IR into register fields and a 32-bit immediate.
module if_id_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Write,
  input  logic        IR_Write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        fetch_busy,
  output logic        fetch_err,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        illegal
);

  localparam logic [31:0] IrNop      = 32'h0000_0013;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpReg   = 7'b0110011;

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] pc_next;

  // Low two bits are forced to zero so the PC stays word aligned.
  assign pc_next = {pc_q[31:2] + 30'd1, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= {PC_RESET[31:2], 2'b00};
      ir_q    <= IrNop;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    busy_d  = busy_q;
    err_d   = err_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (IR_Write) begin
          state_d = StFetch;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          pend_d  = PC_Write;
        end else if (PC_Write) begin
          pc_d = pc_next;
        end
      end
      StFetch: begin
        // Ack takes priority over the timeout check on the final wait cycle.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StIdle;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
          if (pend_q) pc_d = pc_next;
        end else if (cnt_q == TimeoutCnt) begin
          err_d   = 1'b1;
          state_d = StIdle;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign fetch_busy = busy_q;
  assign fetch_err  = err_q;
  assign pc         = pc_q;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  always_comb begin
    imm     = 32'd0;
    illegal = 1'b0;
    case (ir_q[6:0])
      OpImm, OpLoad, OpJalr: imm = {{20{ir_q[31]}}, ir_q[31:20]};
      OpLui, OpAuipc:        imm = {ir_q[31:12], 12'b0};
      OpReg:                 imm = 32'd0;
      default:               illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_if_id_unit.sv
// Self-checking bench for if_id_unit: directed scenarios plus randomized fetch traffic
// compared against a transaction-level model of PC, IR, error flag and decode.
module tb_if_id_unit;

  localparam int TO = 15;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PC_Write = 1'b0, IR_Write = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req, fetch_busy, fetch_err, illegal;
  logic [31:0] imem_addr, pc, imm;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  // Second instance exercises PC wrap from the top of the address space.
  logic        w_pc_write = 1'b0;
  logic        w_req, w_busy, w_err, w_illegal;
  logic [31:0] w_addr, w_pc, w_imm;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1, w_rs2, w_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic        m_err;

  if_id_unit #(.PC_RESET(32'h0000_0000), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .PC_Write(PC_Write), .IR_Write(IR_Write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .fetch_busy(fetch_busy), .fetch_err(fetch_err), .pc(pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .illegal(illegal)
  );

  if_id_unit #(.PC_RESET(32'hFFFF_FFFC), .TIMEOUT(TO)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .PC_Write(w_pc_write), .IR_Write(1'b0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(32'd0),
    .imem_ack(1'b0), .fetch_busy(w_busy), .fetch_err(w_err), .pc(w_pc),
    .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7), .rs1(w_rs1), .rs2(w_rs2),
    .rd(w_rd), .imm(w_imm), .illegal(w_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected decode from the instruction-set rules: {illegal, imm, op, f3, f7, rs1, rs2, rd}.
  function automatic logic [64:0] exp_dec(input logic [31:0] ir);
    logic [31:0] e_imm;
    logic        e_ill;
    logic [6:0]  op;
    op    = ir[6:0];
    e_imm = 32'd0;
    e_ill = 1'b0;
    if (op inside {7'b0010011, 7'b0000011, 7'b1100111}) e_imm = $signed(ir) >>> 20;
    else if (op inside {7'b0110111, 7'b0010111})        e_imm = ir & 32'hFFFF_F000;
    else if (op != 7'b0110011)                           e_ill = 1'b1;
    return {e_ill, e_imm, op, ir[14:12], ir[31:25], ir[19:15], ir[24:20], ir[11:7]};
  endfunction

  function automatic logic [64:0] act_dec();
    return {illegal, imm, opcode, funct3, funct7, rs1, rs2, rd};
  endfunction

  task automatic model_fetch(input logic [31:0] data, input int wt, input logic inc);
    if (wt <= TO) begin
      m_ir = data;
      if (inc) m_pc = m_pc + 32'd4;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Drives one fetch; wt is the number of wait cycles before ack (wt > TO means no ack).
  task automatic do_fetch(input logic [31:0] data, input int wt, input logic inc,
                          output int busy_cycles, output bit addr_stable,
                          output logic [31:0] addr_seen);
    logic [31:0] r;
    IR_Write = 1'b1;
    PC_Write = inc;
    tick();
    // Control-unit noise during FETCH must be ignored.
    r = $urandom;
    IR_Write = r[0];
    PC_Write = r[1];
    busy_cycles = 0;
    addr_stable = 1'b1;
    addr_seen   = imem_addr;
    for (int k = 0; k <= TO; k++) begin
      if (fetch_busy && imem_req) busy_cycles++;
      if (imem_addr !== addr_seen) addr_stable = 1'b0;
      imem_ack   = (k == wt);
      imem_rdata = (k == wt) ? data : $urandom;
      tick();
      if (k == wt) break;
    end
    imem_ack = 1'b0;
    IR_Write = 1'b0;
    PC_Write = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    m_pc = 32'd0; m_ir = NOP; m_err = 1'b0;
    checks++;
    if (pc !== 32'd0 || opcode !== 7'b0010011 || imm !== 32'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_decode: pc=%h op=%b imm=%h ill=%b, required pc=0 op=0010011 imm=0 ill=0",
               pc, opcode, imm, illegal);
    end
    checks++;
    if ({imem_req, fetch_busy, fetch_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: req/busy/err=%b, required 000", {imem_req, fetch_busy, fetch_err});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait;
    int bc; bit st; logic [31:0] a;
    do_fetch(32'hFFF0_8093, 0, 1'b1, bc, st, a);
    model_fetch(32'hFFF0_8093, 0, 1'b1);
    checks++;
    if (opcode !== 7'b0010011 || rd !== 5'd1 || rs1 !== 5'd1 || funct3 !== 3'd0 ||
        imm !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL zero_wait_decode: op=%b rd=%0d rs1=%0d f3=%0d imm=%h, required 0010011 1 1 0 ffffffff",
               opcode, rd, rs1, funct3, imm);
    end
    checks++;
    if (pc !== 32'd4 || bc !== 1 || imem_req !== 1'b0 || fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_wait_ctrl: pc=%h busy_cycles=%0d req=%b busy=%b, required pc=4 1 0 0",
               pc, bc, imem_req, fetch_busy);
    end
  endtask

  task automatic test_wait_states;
    int bc; bit st; logic [31:0] a;
    do_fetch(32'h1234_50B7, 3, 1'b0, bc, st, a);
    model_fetch(32'h1234_50B7, 3, 1'b0);
    checks++;
    if (bc !== 4 || st !== 1'b1 || a !== 32'd4) begin
      errors++;
      $display("FAIL wait_states_req: busy_cycles=%0d addr_stable=%b addr=%h, required 4 1 00000004",
               bc, st, a);
    end
    checks++;
    if (imm !== 32'h1234_5000 || rd !== 5'd1 || pc !== 32'd4) begin
      errors++;
      $display("FAIL wait_states_decode: imm=%h rd=%0d pc=%h, required 12345000 1 00000004",
               imm, rd, pc);
    end
  endtask

  task automatic test_rtype;
    int bc; bit st; logic [31:0] a;
    do_fetch(32'h4020_81B3, 1, 1'b0, bc, st, a);
    model_fetch(32'h4020_81B3, 1, 1'b0);
    checks++;
    if (opcode !== 7'b0110011 || funct7 !== 7'b0100000 || rs2 !== 5'd2 || rs1 !== 5'd1 ||
        rd !== 5'd3 || imm !== 32'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL rtype_decode: op=%b f7=%b rs2=%0d rs1=%0d rd=%0d imm=%h ill=%b, required 0110011 0100000 2 1 3 0 0",
               opcode, funct7, rs2, rs1, rd, imm, illegal);
    end
    do_fetch(32'h0000_007F, 0, 1'b0, bc, st, a);
    model_fetch(32'h0000_007F, 0, 1'b0);
    checks++;
    if (illegal !== 1'b1 || imm !== 32'd0) begin
      errors++;
      $display("FAIL illegal_decode: ill=%b imm=%h, required 1 0", illegal, imm);
    end
  endtask

  task automatic test_ack_on_last;
    int bc; bit st; logic [31:0] a;
    do_fetch(32'hABCD_E013, TO, 1'b1, bc, st, a);
    model_fetch(32'hABCD_E013, TO, 1'b1);
    checks++;
    if (fetch_err !== 1'b0 || act_dec() !== exp_dec(m_ir) || pc !== m_pc || bc !== TO + 1) begin
      errors++;
      $display("FAIL ack_on_last: err=%b dec=%h pc=%h busy_cycles=%0d, required 0 %h %h %0d",
               fetch_err, act_dec(), pc, bc, exp_dec(m_ir), m_pc, TO + 1);
    end
  endtask

  task automatic test_timeout;
    int bc; bit st; logic [31:0] a;
    do_fetch(32'h0000_0037, TO + 1, 1'b1, bc, st, a);
    model_fetch(32'h0000_0037, TO + 1, 1'b1);
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || fetch_busy !== 1'b0 || bc !== TO + 1) begin
      errors++;
      $display("FAIL timeout_ctrl: err=%b req=%b busy=%b busy_cycles=%0d, required 1 0 0 %0d",
               fetch_err, imem_req, fetch_busy, bc, TO + 1);
    end
    checks++;
    if (pc !== m_pc || act_dec() !== exp_dec(m_ir)) begin
      errors++;
      $display("FAIL timeout_state: pc=%h dec=%h, required %h %h", pc, act_dec(), m_pc,
               exp_dec(m_ir));
    end
  endtask

  task automatic test_random;
    logic [6:0] ops [9];
    logic [31:0] r, data;
    logic [31:0] pc_before;
    int bc, wt, exp_bc, kind;
    bit st;
    logic [31:0] a;
    logic inc;
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111,
            7'b0110011, 7'b1101111, 7'b1100011, 7'b0000000};
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        // Idle cycles: PC advances on PC_Write; stray acks are ignored.
        for (int c = 0; c < 3; c++) begin
          r = $urandom;
          PC_Write   = r[0];
          imem_ack   = r[1];
          imem_rdata = $urandom;
          if (r[0]) m_pc = m_pc + 32'd4;
          tick();
        end
        PC_Write = 1'b0;
        imem_ack = 1'b0;
        exp_bc = 0;
        bc = 0;
        st = 1'b1;
        a = m_pc;
        pc_before = m_pc;
      end else begin
        r = $urandom;
        data = {r[31:7], ops[$urandom_range(0, 8)]};
        wt = $urandom_range(0, TO + 2);
        inc = r[3];
        pc_before = m_pc;
        do_fetch(data, wt, inc, bc, st, a);
        model_fetch(data, wt, inc);
        exp_bc = (wt <= TO) ? wt + 1 : TO + 1;
      end
      checks++;
      if (pc !== m_pc || act_dec() !== exp_dec(m_ir) || fetch_err !== m_err ||
          imem_req !== 1'b0 || fetch_busy !== 1'b0 || bc !== exp_bc || st !== 1'b1 ||
          a !== pc_before) begin
        errors++;
        $display("FAIL random_%0d: pc=%h dec=%h err=%b req=%b busy=%b bc=%0d stable=%b addr=%h, required %h %h %b 0 0 %0d 1 %h",
                 t, pc, act_dec(), fetch_err, imem_req, fetch_busy, bc, st, a,
                 m_pc, exp_dec(m_ir), m_err, exp_bc, pc_before);
      end
    end
  endtask

  task automatic test_reset_mid_fetch;
    IR_Write = 1'b1;
    PC_Write = 1'b1;
    tick();
    IR_Write = 1'b0;
    PC_Write = 1'b0;
    tick();
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0033;
    tick();
    imem_ack = 1'b0;
    m_pc = 32'd0; m_ir = NOP; m_err = 1'b0;
    checks++;
    if (act_dec() !== exp_dec(NOP) || pc !== 32'd0 || imem_req !== 1'b0 ||
        fetch_busy !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fetch: dec=%h pc=%h req=%b busy=%b err=%b, required %h 0 0 0 0",
               act_dec(), pc, imem_req, fetch_busy, fetch_err, exp_dec(NOP));
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pc_wrap;
    checks++;
    if (w_pc !== 32'hFFFF_FFFC || w_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_reset: pc=%h addr=%h, required fffffffc", w_pc, w_addr);
    end
    w_pc_write = 1'b1;
    tick();
    w_pc_write = 1'b0;
    checks++;
    if (w_pc !== 32'd0) begin
      errors++;
      $display("FAIL wrap_advance: pc=%h, required 00000000", w_pc);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_rtype();
    test_ack_on_last();
    test_timeout();
    test_random();
    test_reset_mid_fetch();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
